// File: rtl/cpu7_icu_fetch.sv
// cpu7_icu_fetch: instruction-fetch bus unit feeding the IFU.
// Takes one ic1 fetch request at a time, reads the enclosing 8-byte-aligned
// doubleword as two 32-bit beats on the SRAM-like instruction bus, and
// returns it as a single 64-bit ic2 data pulse. A cancel abandons the
// current fetch; address beats already issued are remembered in drop_q and
// their data is swallowed when it comes back.
// Optional feature: define CPU7_ICU_LINEBUF_EN for a one-entry 64-bit line
// buffer that serves repeat fetches of the same doubleword without bus traffic.
//
// Handshakes: ic1 transfers when ifu_icu_req_ic1 && icu_ifu_ack_ic1 in the
// same cycle. The bus address beat transfers when inst_sram_req &&
// inst_sram_addr_ok; once inst_sram_req rises, it and inst_sram_addr are held
// unchanged until that happens. Each inst_sram_data_ok returns one beat, in
// issue order.
module cpu7_icu_fetch (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ifu_icu_req_ic1,
  input  logic [31:0] ifu_icu_addr_ic1,
  output logic        icu_ifu_ack_ic1,
  input  logic        ifu_icu_cancel,
  output logic [63:0] icu_ifu_data_ic2,
  output logic        icu_ifu_data_valid_ic2,
  input  logic        ifu_icu_inv,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  output logic [2:0]  dbg_state_o,
  output logic [2:0]  dbg_drop_cnt_o
);

`ifdef CPU7_ICU_LINEBUF_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_A0 = 3'd1, S_A1 = 3'd2, S_WAIT = 3'd3, S_HOLD = 3'd4, S_HIT = 3'd5
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_A0 = 3'd1, S_A1 = 3'd2, S_WAIT = 3'd3, S_HOLD = 3'd4
  } state_e;
`endif

  state_e      state_q;
  logic        req_q;
  logic [31:0] addr_q;
  logic [28:0] base_q;     // doubleword address of the live fetch
  logic        pend_q;     // a new fetch was acked while sitting in HOLD
  logic [1:0]  issued_q;   // address beats of the live fetch accepted by the bus
  logic [1:0]  ret_q;      // data beats of the live fetch received
  logic [31:0] lo_q;       // beat0 staging so the output holds between pulses
  logic [63:0] data_q;
  logic        valid_q;
  logic [2:0]  drop_q;
  logic [2:0]  drop_d;

  logic        cancel_act;
  logic        in_addr;
  logic        beat_pend;
  logic        drop_beat;
  logic        live_beat;
  logic        beat1_done;
  logic [1:0]  live_out;
  logic [3:0]  drop_sum;
  logic        unused_bits;

  assign icu_ifu_ack_ic1        = ifu_icu_req_ic1 & ((state_q == S_IDLE) | ifu_icu_cancel);
  assign icu_ifu_data_valid_ic2 = valid_q & ~ifu_icu_cancel;
  assign icu_ifu_data_ic2       = data_q;
  assign inst_sram_req          = req_q;
  assign inst_sram_addr         = addr_q;
  assign dbg_state_o            = state_q;
  assign dbg_drop_cnt_o         = drop_q;

  // A cancel in IDLE has nothing to abandon.
  assign cancel_act = ifu_icu_cancel & (state_q != S_IDLE);
  assign in_addr    = (state_q == S_A0) | (state_q == S_A1);
  // An address beat still waiting for addr_ok must finish its handshake.
  assign beat_pend  = (in_addr | (state_q == S_HOLD)) & ~inst_sram_addr_ok;
  assign drop_beat  = inst_sram_data_ok & (drop_q != 3'd0);
  assign live_beat  = inst_sram_data_ok & (drop_q == 3'd0) &
                      ((state_q == S_A1) | (state_q == S_WAIT));
  assign beat1_done = live_beat & (state_q == S_WAIT) & (ret_q == 2'd1) & ~cancel_act;
  assign unused_bits = ^{ifu_icu_inv, ifu_icu_addr_ic1[2:0]};

`ifdef CPU7_ICU_LINEBUF_EN
  logic        lb_valid_q;
  logic [28:0] lb_tag_q;
  logic [63:0] lb_data_q;
  logic        lb_hit;

  assign lb_hit = lb_valid_q & (lb_tag_q == ifu_icu_addr_ic1[31:3]);

  // Line buffer: refilled by every completed live fetch; invalidate wins.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lb_valid_q <= 1'b0;
      lb_tag_q   <= '0;
      lb_data_q  <= '0;
    end else if (ifu_icu_inv) begin
      lb_valid_q <= 1'b0;
    end else if (beat1_done) begin
      lb_valid_q <= 1'b1;
      lb_tag_q   <= base_q;
      lb_data_q  <= {inst_sram_rdata, lo_q};
    end
  end
`endif

  // Stale-beat bookkeeping: retire one dropped beat per data_ok, and on a
  // cancel add every beat of the live fetch that will still return data.
  always_comb begin
    live_out = issued_q - ret_q - {1'b0, live_beat};
    drop_sum = {1'b0, drop_q} - {3'b000, drop_beat};
    if (cancel_act) begin
      drop_sum = drop_sum + {2'b00, live_out} + {3'b000, in_addr};
    end
    drop_d = drop_sum[2:0];
  end

  drop_ovf_a: assert property (@(posedge clk) disable iff (!resetn) !drop_sum[3]);

  // Fetch FSM with registered bus request, address and data outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      req_q    <= 1'b0;
      addr_q   <= '0;
      base_q   <= '0;
      pend_q   <= 1'b0;
      issued_q <= '0;
      ret_q    <= '0;
      lo_q     <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      drop_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      drop_q  <= drop_d;
      if (cancel_act) begin
        issued_q <= '0;
        ret_q    <= '0;
        if (beat_pend) begin
          state_q <= S_HOLD;
          pend_q  <= icu_ifu_ack_ic1;
          if (icu_ifu_ack_ic1) base_q <= ifu_icu_addr_ic1[31:3];
        end else if (icu_ifu_ack_ic1) begin
          base_q <= ifu_icu_addr_ic1[31:3];
`ifdef CPU7_ICU_LINEBUF_EN
          if (lb_hit) begin
            state_q <= S_HIT;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            data_q  <= lb_data_q;
          end else
`endif
          begin
            state_q <= S_A0;
            req_q   <= 1'b1;
            addr_q  <= {ifu_icu_addr_ic1[31:3], 3'b000};
          end
        end else begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            if (icu_ifu_ack_ic1) begin
              base_q <= ifu_icu_addr_ic1[31:3];
`ifdef CPU7_ICU_LINEBUF_EN
              if (lb_hit) begin
                state_q <= S_HIT;
                valid_q <= 1'b1;
                data_q  <= lb_data_q;
              end else
`endif
              begin
                state_q <= S_A0;
                req_q   <= 1'b1;
                addr_q  <= {ifu_icu_addr_ic1[31:3], 3'b000};
              end
            end
          end
          S_A0: begin
            if (inst_sram_addr_ok) begin
              issued_q <= issued_q + 2'd1;
              addr_q   <= {base_q, 3'b100};
              state_q  <= S_A1;
            end
          end
          S_A1: begin
            if (inst_sram_addr_ok) begin
              issued_q <= issued_q + 2'd1;
              req_q    <= 1'b0;
              state_q  <= S_WAIT;
            end
            if (live_beat) begin
              lo_q  <= inst_sram_rdata;
              ret_q <= 2'd1;
            end
          end
          S_WAIT: begin
            if (live_beat) begin
              if (ret_q == 2'd0) begin
                lo_q  <= inst_sram_rdata;
                ret_q <= 2'd1;
              end else begin
                data_q   <= {inst_sram_rdata, lo_q};
                valid_q  <= 1'b1;
                ret_q    <= '0;
                issued_q <= '0;
                state_q  <= S_IDLE;
              end
            end
          end
          S_HOLD: begin
            if (inst_sram_addr_ok) begin
              if (pend_q) begin
                pend_q  <= 1'b0;
                state_q <= S_A0;
                addr_q  <= {base_q, 3'b000};
              end else begin
                req_q   <= 1'b0;
                state_q <= S_IDLE;
              end
            end
          end
`ifdef CPU7_ICU_LINEBUF_EN
          S_HIT: state_q <= S_IDLE;
`endif
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu7_icu_fetch.sv
// Directed testbench for cpu7_icu_fetch: a configurable SRAM-like bus
// responder, a valid-pulse monitor, and one task per scenario.
`timescale 1ns/1ps
module tb_cpu7_icu_fetch;
  logic        clk;
  logic        resetn;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic        cancel;
  logic [63:0] data_ic2;
  logic        data_valid;
  logic        inv;
  logic        sram_req;
  logic [31:0] sram_addr;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic [2:0]  dbg_state;
  logic [2:0]  dbg_drop;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // bus responder configuration and state
  int          addr_delay = 0;
  int          data_lat = 1;
  logic        bus_stall = 1'b0;
  int          wcnt = 0;
  int          hold_viol = 0;
  logic [31:0] last_addr = '0;
  logic [31:0] rsp_q[$];
  int          rdy_q[$];
  logic [31:0] acc_addr_q[$];
  int          acc_wait_q[$];

  // valid-pulse monitor
  int          vcount = 0;
  int          v_cyc_q[$];
  logic [63:0] v_data_q[$];

  // expected doublewords, pushed by each scenario before it compares
  logic [63:0] exp_q[$];

  cpu7_icu_fetch dut (
    .clk                    (clk),
    .resetn                 (resetn),
    .ifu_icu_req_ic1        (req),
    .ifu_icu_addr_ic1       (addr),
    .icu_ifu_ack_ic1        (ack),
    .ifu_icu_cancel         (cancel),
    .icu_ifu_data_ic2       (data_ic2),
    .icu_ifu_data_valid_ic2 (data_valid),
    .ifu_icu_inv            (inv),
    .inst_sram_req          (sram_req),
    .inst_sram_addr         (sram_addr),
    .inst_sram_addr_ok      (addr_ok),
    .inst_sram_data_ok      (data_ok),
    .inst_sram_rdata        (rdata),
    .dbg_state_o            (dbg_state),
    .dbg_drop_cnt_o         (dbg_drop)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h1c000000) return 32'h11111111;
    if (a == 32'h1c000004) return 32'h22222222;
    return a ^ 32'h5a5a0000;
  endfunction

  function automatic logic [63:0] mem_dw(input logic [31:0] a);
    logic [31:0] b;
    b = {a[31:3], 3'b000};
    return {mem_word(b + 32'd4), mem_word(b)};
  endfunction

  // bus responder: in-order data, addr_ok after addr_delay waiting cycles
  always @(negedge clk) begin
    if (!resetn) begin
      addr_ok = 1'b0;
      data_ok = 1'b0;
      rdata   = '0;
      wcnt    = 0;
      rsp_q.delete();
      rdy_q.delete();
    end else begin
      data_ok = 1'b0;
      rdata   = '0;
      if (rsp_q.size() > 0 && rdy_q[0] <= cyc) begin
        data_ok = 1'b1;
        rdata   = rsp_q.pop_front();
        rdy_q.delete(0);
      end
      addr_ok = 1'b0;
      if (sram_req) begin
        if (wcnt > 0 && sram_addr !== last_addr) hold_viol++;
        last_addr = sram_addr;
        if (!bus_stall && wcnt >= addr_delay) begin
          addr_ok = 1'b1;
          acc_addr_q.push_back(sram_addr);
          acc_wait_q.push_back(wcnt);
          rsp_q.push_back(mem_word(sram_addr));
          rdy_q.push_back(cyc + data_lat);
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // monitor: record every delivered pulse with its cycle
  always @(negedge clk) begin
    #2;
    if (resetn && data_valid === 1'b1) begin
      vcount++;
      v_cyc_q.push_back(cyc);
      v_data_q.push_back(data_ic2);
    end
  end

  task automatic apply_reset();
    resetn = 1'b0;
    req = 1'b0; addr = '0; cancel = 1'b0; inv = 1'b0;
    bus_stall = 1'b0; addr_delay = 0; data_lat = 1;
    acc_addr_q.delete();
    acc_wait_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  // driver: one request, then wait (bounded) for the pulse and a few cycles more
  task automatic do_fetch(input logic [31:0] a, output logic ack_seen, output int lat,
                          output logic [63:0] d, output int np);
    int t0;
    int n0;
    n0 = vcount;
    @(negedge clk);
    req = 1'b1; addr = a;
    #1;
    ack_seen = ack;
    t0 = cyc;
    @(negedge clk);
    req = 1'b0; addr = '0;
    for (int i = 0; i < 60 && vcount == n0; i++) begin
      @(negedge clk); #3;
    end
    repeat (4) @(negedge clk);
    #3;
    np = vcount - n0;
    if (np > 0) begin
      lat = v_cyc_q[n0] - t0;
      d   = v_data_q[n0];
    end else begin
      lat = -1;
      d   = '0;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; req = 1'b0; cancel = 1'b0; inv = 1'b0; addr = '0;
    @(negedge clk); #1;
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", ack); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", data_valid); end
    checks++; if (data_ic2 !== 64'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", data_ic2); end
    checks++; if (sram_req !== 1'b0) begin errors++; $display("FAIL reset_sram_req: got %b expected 0", sram_req); end
    checks++; if (sram_addr !== 32'h0) begin errors++; $display("FAIL reset_sram_addr: got %h expected 0", sram_addr); end
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    checks++; if (dbg_drop !== 3'd0) begin errors++; $display("FAIL reset_drop: got %0d expected 0", dbg_drop); end
  endtask

  task automatic test_basic_fetch();
    logic a_s; int lat; logic [63:0] d; int np; logic [63:0] e;
    apply_reset();
    exp_q.push_back(64'h22222222_11111111);
    do_fetch(32'h1c000004, a_s, lat, d, np);
    e = exp_q.pop_front();
    checks++; if (a_s !== 1'b1) begin errors++; $display("FAIL basic_ack: got %b expected 1", a_s); end
    checks++; if (np != 1) begin errors++; $display("FAIL basic_pulses: got %0d expected 1", np); end
    checks++; if (lat != 4) begin errors++; $display("FAIL basic_latency: got %0d expected 4", lat); end
    checks++; if (d !== e) begin errors++; $display("FAIL basic_data: got %h expected %h", d, e); end
    checks++; if (acc_addr_q.size() != 2) begin errors++; $display("FAIL basic_beats: got %0d expected 2", acc_addr_q.size()); end
    else begin
      checks++; if (acc_addr_q[0] !== 32'h1c000000) begin errors++; $display("FAIL basic_addr0: got %h expected 1c000000", acc_addr_q[0]); end
      checks++; if (acc_addr_q[1] !== 32'h1c000004) begin errors++; $display("FAIL basic_addr1: got %h expected 1c000004", acc_addr_q[1]); end
    end
    checks++; if (data_ic2 !== e) begin errors++; $display("FAIL basic_data_hold: got %h expected %h", data_ic2, e); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_low: got %b expected 0", data_valid); end
  endtask

  task automatic test_addr_delay();
    logic a_s; int lat; logic [63:0] d; int np; logic [63:0] e;
    apply_reset();
    addr_delay = 3;
    hold_viol = 0;
    exp_q.push_back(mem_dw(32'h1c000040));
    do_fetch(32'h1c000040, a_s, lat, d, np);
    e = exp_q.pop_front();
    checks++; if (np != 1) begin errors++; $display("FAIL delay_pulses: got %0d expected 1", np); end
    checks++; if (lat != 10) begin errors++; $display("FAIL delay_latency: got %0d expected 10", lat); end
    checks++; if (d !== e) begin errors++; $display("FAIL delay_data: got %h expected %h", d, e); end
    checks++; if (acc_wait_q.size() < 1 || acc_wait_q[0] != 3) begin errors++; $display("FAIL delay_wait0: got %0d expected 3", acc_wait_q.size() > 0 ? acc_wait_q[0] : -1); end
    checks++; if (hold_viol != 0) begin errors++; $display("FAIL delay_addr_hold: got %0d expected 0", hold_viol); end
  endtask

  task automatic test_cancel_wait();
    int n0; logic [63:0] e;
    apply_reset();
    data_lat = 4;
    n0 = vcount;
    exp_q.push_back(mem_dw(32'h1c000100));
    @(negedge clk); req = 1'b1; addr = 32'h1c000080;
    @(negedge clk); req = 1'b0; addr = '0;
    @(negedge clk);
    @(negedge clk); #1;
    checks++; if (dbg_state !== 3'd3) begin errors++; $display("FAIL cw_state_wait: got %0d expected 3", dbg_state); end
    req = 1'b1; addr = 32'h1c000100; cancel = 1'b1;
    #1;
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL cw_ack: got %b expected 1", ack); end
    @(posedge clk); #1;
    data_lat = 1;
    @(negedge clk);
    req = 1'b0; addr = '0; cancel = 1'b0;
    #1;
    checks++; if (dbg_drop !== 3'd2) begin errors++; $display("FAIL cw_drop: got %0d expected 2", dbg_drop); end
    checks++; if (dbg_state !== 3'd1) begin errors++; $display("FAIL cw_state_a0: got %0d expected 1", dbg_state); end
    for (int i = 0; i < 40 && vcount == n0; i++) begin @(negedge clk); #3; end
    repeat (4) @(negedge clk);
    #3;
    e = exp_q.pop_front();
    checks++; if (vcount - n0 != 1) begin errors++; $display("FAIL cw_pulses: got %0d expected 1", vcount - n0); end
    else begin
      checks++; if (v_data_q[n0] !== e) begin errors++; $display("FAIL cw_data: got %h expected %h", v_data_q[n0], e); end
    end
    checks++; if (dbg_drop !== 3'd0) begin errors++; $display("FAIL cw_drop_end: got %0d expected 0", dbg_drop); end
  endtask

  task automatic test_cancel_hold();
    int n0; logic [63:0] e;
    apply_reset();
    bus_stall = 1'b1;
    n0 = vcount;
    exp_q.push_back(mem_dw(32'h1c000300));
    @(negedge clk); req = 1'b1; addr = 32'h1c000200;
    @(negedge clk); req = 1'b0; addr = '0;
    @(negedge clk);
    req = 1'b1; addr = 32'h1c000300; cancel = 1'b1;
    #1;
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL ch_ack: got %b expected 1", ack); end
    @(negedge clk);
    req = 1'b0; addr = '0; cancel = 1'b0;
    #1;
    checks++; if (dbg_state !== 3'd4) begin errors++; $display("FAIL ch_state_hold: got %0d expected 4", dbg_state); end
    checks++; if (dbg_drop !== 3'd1) begin errors++; $display("FAIL ch_drop: got %0d expected 1", dbg_drop); end
    checks++; if (sram_req !== 1'b1) begin errors++; $display("FAIL ch_req_held: got %b expected 1", sram_req); end
    @(negedge clk); #1;
    checks++; if (sram_addr !== 32'h1c000200) begin errors++; $display("FAIL ch_addr_held: got %h expected 1c000200", sram_addr); end
    @(posedge clk); #1;
    bus_stall = 1'b0;
    for (int i = 0; i < 40 && vcount == n0; i++) begin @(negedge clk); #3; end
    repeat (4) @(negedge clk);
    #3;
    e = exp_q.pop_front();
    checks++; if (vcount - n0 != 1) begin errors++; $display("FAIL ch_pulses: got %0d expected 1", vcount - n0); end
    else begin
      checks++; if (v_data_q[n0] !== e) begin errors++; $display("FAIL ch_data: got %h expected %h", v_data_q[n0], e); end
    end
    checks++; if (acc_addr_q.size() != 3) begin errors++; $display("FAIL ch_beats: got %0d expected 3", acc_addr_q.size()); end
    else begin
      checks++; if (acc_addr_q[0] !== 32'h1c000200) begin errors++; $display("FAIL ch_addr0: got %h expected 1c000200", acc_addr_q[0]); end
      checks++; if (acc_addr_q[1] !== 32'h1c000300) begin errors++; $display("FAIL ch_addr1: got %h expected 1c000300", acc_addr_q[1]); end
      checks++; if (acc_addr_q[2] !== 32'h1c000304) begin errors++; $display("FAIL ch_addr2: got %h expected 1c000304", acc_addr_q[2]); end
    end
    checks++; if (dbg_drop !== 3'd0) begin errors++; $display("FAIL ch_drop_end: got %0d expected 0", dbg_drop); end
  endtask

  task automatic test_cancel_valid();
    int n0;
    apply_reset();
    n0 = vcount;
    @(negedge clk); req = 1'b1; addr = 32'h1c000400;
    @(negedge clk); req = 1'b0; addr = '0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    cancel = 1'b1;
    #1;
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL cv_valid_cancel: got %b expected 0", data_valid); end
    @(negedge clk);
    cancel = 1'b0;
    #1;
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL cv_valid_after: got %b expected 0", data_valid); end
    repeat (3) @(negedge clk);
    #3;
    checks++; if (vcount != n0) begin errors++; $display("FAIL cv_pulses: got %0d expected 0", vcount - n0); end
  endtask

  task automatic test_cancel_last_beat();
    int n0; logic a_s; int lat; logic [63:0] d; int np; logic [63:0] e;
    apply_reset();
    n0 = vcount;
    @(negedge clk); req = 1'b1; addr = 32'h1c000500;
    @(negedge clk); req = 1'b0; addr = '0;
    @(negedge clk);
    @(negedge clk); #1;
    checks++; if (dbg_state !== 3'd3) begin errors++; $display("FAIL clb_state_wait: got %0d expected 3", dbg_state); end
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    #1;
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL clb_state_idle: got %0d expected 0", dbg_state); end
    checks++; if (dbg_drop !== 3'd0) begin errors++; $display("FAIL clb_drop: got %0d expected 0", dbg_drop); end
    repeat (5) @(negedge clk);
    #3;
    checks++; if (vcount != n0) begin errors++; $display("FAIL clb_pulses: got %0d expected 0", vcount - n0); end
    exp_q.push_back(mem_dw(32'h1c000508));
    do_fetch(32'h1c000508, a_s, lat, d, np);
    e = exp_q.pop_front();
    checks++; if (np != 1 || d !== e) begin errors++; $display("FAIL clb_refetch: got %0d pulses data %h expected 1 pulse data %h", np, d, e); end
    checks++; if (lat != 4) begin errors++; $display("FAIL clb_refetch_lat: got %0d expected 4", lat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs[3];
    logic a_s; int lat; logic [63:0] d; int np; logic [63:0] e;
    apply_reset();
    addr_delay = 1;
    data_lat = 2;
    addrs[0] = 32'h1c000600; addrs[1] = 32'h1c00060c; addrs[2] = 32'h1c000ff8;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(mem_dw(addrs[k]));
      do_fetch(addrs[k], a_s, lat, d, np);
      e = exp_q.pop_front();
      checks++; if (a_s !== 1'b1) begin errors++; $display("FAIL b2b_ack%0d: got %b expected 1", k, a_s); end
      checks++; if (np != 1) begin errors++; $display("FAIL b2b_pulses%0d: got %0d expected 1", k, np); end
      checks++; if (lat != 7) begin errors++; $display("FAIL b2b_latency%0d: got %0d expected 7", k, lat); end
      checks++; if (d !== e) begin errors++; $display("FAIL b2b_data%0d: got %h expected %h", k, d, e); end
    end
  endtask

  task automatic test_linebuf();
    logic a_s; int lat; logic [63:0] d; int np; int nb; logic [63:0] e;
    apply_reset();
    e = 64'h22222222_11111111;
    do_fetch(32'h1c000000, a_s, lat, d, np);
    checks++; if (np != 1 || d !== e || lat != 4) begin errors++; $display("FAIL lb_first: got np=%0d lat=%0d data=%h expected np=1 lat=4 data=%h", np, lat, d, e); end
    nb = acc_addr_q.size();
    do_fetch(32'h1c000000, a_s, lat, d, np);
    checks++; if (np != 1 || d !== e) begin errors++; $display("FAIL lb_second: got np=%0d data=%h expected np=1 data=%h", np, d, e); end
`ifdef CPU7_ICU_LINEBUF_EN
    checks++; if (lat != 1) begin errors++; $display("FAIL lb_hit_lat: got %0d expected 1", lat); end
    checks++; if (acc_addr_q.size() != nb) begin errors++; $display("FAIL lb_hit_bus: got %0d beats expected %0d", acc_addr_q.size(), nb); end
`else
    checks++; if (lat != 4) begin errors++; $display("FAIL lb_nobuf_lat: got %0d expected 4", lat); end
    checks++; if (acc_addr_q.size() != nb + 2) begin errors++; $display("FAIL lb_nobuf_bus: got %0d beats expected %0d", acc_addr_q.size(), nb + 2); end
`endif
    @(negedge clk); inv = 1'b1;
    @(negedge clk); inv = 1'b0;
    nb = acc_addr_q.size();
    do_fetch(32'h1c000000, a_s, lat, d, np);
    checks++; if (np != 1 || d !== e || lat != 4) begin errors++; $display("FAIL lb_after_inv: got np=%0d lat=%0d data=%h expected np=1 lat=4 data=%h", np, lat, d, e); end
    checks++; if (acc_addr_q.size() != nb + 2) begin errors++; $display("FAIL lb_inv_bus: got %0d beats expected %0d", acc_addr_q.size(), nb + 2); end
  endtask

  initial begin
    resetn = 1'b0; req = 1'b0; addr = '0; cancel = 1'b0; inv = 1'b0;
    test_reset();
    test_basic_fetch();
    test_addr_delay();
    test_cancel_wait();
    test_cancel_hold();
    test_cancel_valid();
    test_cancel_last_beat();
    test_back_to_back();
    test_linebuf();
    checks++; if (hold_viol != 0) begin errors++; $display("FAIL bus_hold_rule: got %0d violations expected 0", hold_viol); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
